step_profile_executor: RTL and testbench

- Consumes the five motion parameters produced by the profile calculator: N, nn, t0, tna, delta (array index 0..4).
- Emits a trapezoidal step-pulse train for one stepper axis: accelerate, cruise, then decelerate.
- Sits between the parameter calculator and the driver's STEP pin. One instance is used per axis.
- Reports busy, finish and the number of steps emitted.

---
 rtl/step_profile_executor.sv | 112 +++++++++++
 tb/tb_step_profile_executor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/step_profile_executor.sv
// step_profile_executor: trapezoidal STEP pulse train (accel, cruise, decel) for one stepper axis.
module step_profile_executor #(
  parameter int PULSE_W    = 4,
  parameter int MIN_PERIOD = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [0:4][31:0] i_par,
  input  logic            i_start,
  input  logic            i_abort,
  output logic            o_step,
  output logic            o_busy,
  output logic            o_finish,
  output logic            o_aborted,
  output logic [31:0]     o_step_count
);
  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;
  state_t      r_state;
  logic        r_step, r_busy, r_finish, r_aborted;
  logic [31:0] r_count, r_n, r_na, r_t0, r_tna, r_delta, r_raw, r_per, r_cnt;
  logic [31:0] w_na0, w_raw0, w_raw;
  function automatic logic [31:0] raw_p(input logic [31:0] k, prev, n, na, t0, tna, dl);
    logic [31:0] d;
    logic [32:0] s;
    d = (prev >= dl) ? prev - dl : 32'd0;
    s = {1'b0, prev} + {1'b0, dl};
    if (k < na) return (k == 0) ? t0 : ((d > tna) ? d : tna);
    return (k < n - na) ? tna : ((s > {1'b0, t0}) ? t0 : s[31:0]);
  endfunction
  function automatic state_t phase(input logic [31:0] k, n, na);
    return (k < na) ? ACCEL : ((k < n - na) ? CRUISE : DECEL);
  endfunction
  function automatic logic [31:0] clamp(input logic [31:0] p);
    return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
  endfunction
  // The recurrence runs on unclamped periods; only the timed period is clamped.
  assign w_na0  = (i_par[1] < (i_par[0] >> 1)) ? i_par[1] : (i_par[0] >> 1);
  assign w_raw0 = raw_p(32'd0, 32'd0, i_par[0], w_na0, i_par[2], i_par[3], i_par[4]);
  assign w_raw  = raw_p(r_count, r_raw, r_n, r_na, r_t0, r_tna, r_delta);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_step    <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_aborted <= 1'b0;
      r_count   <= '0;
      r_n       <= '0;
      r_na      <= '0;
      r_t0      <= '0;
      r_tna     <= '0;
      r_delta   <= '0;
      r_raw     <= '0;
      r_per     <= '0;
      r_cnt     <= '0;
    end else begin
      r_finish  <= 1'b0;
      r_aborted <= 1'b0;
      if (r_busy && i_abort) begin
        r_state   <= IDLE;
        r_step    <= 1'b0;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else if (r_state == IDLE) begin
        if (i_start) begin
          r_n     <= i_par[0];
          r_na    <= w_na0;
          r_t0    <= i_par[2];
          r_tna   <= i_par[3];
          r_delta <= i_par[4];
          r_raw   <= w_raw0;
          r_per   <= clamp(w_raw0);
          r_cnt   <= clamp(w_raw0);
          if (i_par[0] == 0) begin
            r_count  <= '0;
            r_finish <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_count <= 32'd1;
            r_step  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= phase(32'd0, i_par[0], w_na0);
          end
        end
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end else if (r_cnt == 32'd1) begin
        if (r_count == r_n) begin
          r_step   <= 1'b0;
          r_busy   <= 1'b0;
          r_finish <= 1'b1;
          r_state  <= DONE;
        end else begin
          r_step  <= 1'b1;
          r_count <= r_count + 32'd1;
          r_raw   <= w_raw;
          r_per   <= clamp(w_raw);
          r_cnt   <= clamp(w_raw);
          r_state <= phase(r_count, r_n, r_na);
        end
      end else begin
        r_cnt  <= r_cnt - 32'd1;
        r_step <= (r_per - r_cnt + 32'd1) < 32'(PULSE_W);
      end
    end
  end
  assign o_step       = r_step;
  assign o_busy       = r_busy;
  assign o_finish     = r_finish;
  assign o_aborted    = r_aborted;
  assign o_step_count = r_count;
endmodule

// File: tb/tb_step_profile_executor.sv
// tb_step_profile_executor: directed checks of step timing, completion, abort and async reset.
module tb_step_profile_executor;
  logic             clk = 0, rst = 1, start = 0, abort = 0;
  logic [0:4][31:0] par = '0;
  logic             step, busy, finish, aborted;
  logic [31:0]      step_count;
  int vectors = 0, miscompares = 0;
  int e_cyc[16];
  int ne, fin, wbad, cnt_first;
  logic busy_fin;
  step_profile_executor #(.PULSE_W(4), .MIN_PERIOD(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_par(par), .i_start(start), .i_abort(abort),
    .o_step(step), .o_busy(busy), .o_finish(finish), .o_aborted(aborted),
    .o_step_count(step_count)
  );
  always #5 clk = ~clk;
  task automatic set_par(input int n, nn, t0, tna, dl);
    par[0] = n; par[1] = nn; par[2] = t0; par[3] = tna; par[4] = dl;
  endtask
  task automatic capture(input int limit, input bit hold);
    int cyc = 0;
    int hi = 0;
    logic prev = 0;
    ne = 0; fin = -1; wbad = 0; cnt_first = -1; busy_fin = 1;
    while (cyc < limit && fin < 0) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 0;
      if (step && !prev) begin
        if (ne < 16) e_cyc[ne] = cyc;
        ne++;
        if (ne == 1) cnt_first = int'(step_count);
      end
      if (step) hi++;
      else begin
        if (prev && hi != 4) wbad++;
        hi = 0;
      end
      if (finish) begin fin = cyc; busy_fin = busy; end
      prev = step;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    vectors++; if ({step, busy, finish, aborted} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {step, busy, finish, aborted}); end
    vectors++; if (step_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", step_count); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_nominal;
    int exp[6] = '{1, 101, 171, 211, 251, 321};
    set_par(6, 2, 100, 40, 30); start = 1;
    capture(600, 0);
    vectors++; if (ne !== 6) begin miscompares++; $display("FAIL nom_edges got %0d want 6", ne); end
    for (int i = 0; i < 6; i++) begin
      vectors++; if (e_cyc[i] !== exp[i]) begin miscompares++; $display("FAIL nom_edge%0d got %0d want %0d", i, e_cyc[i], exp[i]); end
    end
    vectors++; if (fin !== 421) begin miscompares++; $display("FAIL nom_finish got %0d want 421", fin); end
    vectors++; if (busy_fin !== 1'b0) begin miscompares++; $display("FAIL nom_busy_at_finish got %b want 0", busy_fin); end
    vectors++; if (step_count !== 32'd6) begin miscompares++; $display("FAIL nom_count got %0d want 6", step_count); end
    vectors++; if (wbad !== 0) begin miscompares++; $display("FAIL nom_width got %0d bad pulses want 0", wbad); end
    @(negedge clk);
    vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL nom_finish_pulse got %b want 0", finish); end
  endtask
  task automatic test_short;
    int exp[3] = '{1, 101, 141};
    set_par(3, 5, 100, 40, 30); start = 1;
    capture(400, 0);
    vectors++; if (ne !== 3) begin miscompares++; $display("FAIL short_edges got %0d want 3", ne); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (e_cyc[i] !== exp[i]) begin miscompares++; $display("FAIL short_edge%0d got %0d want %0d", i, e_cyc[i], exp[i]); end
    end
    vectors++; if (fin !== 211) begin miscompares++; $display("FAIL short_finish got %0d want 211", fin); end
    @(negedge clk);
  endtask
  task automatic test_zero_and_clamp;
    set_par(0, 3, 100, 40, 30); start = 1;
    capture(20, 0);
    vectors++; if (fin !== 1 || ne !== 0) begin miscompares++; $display("FAIL zero_move got fin=%0d edges=%0d want fin=1 edges=0", fin, ne); end
    @(negedge clk);
    set_par(2, 0, 100, 3, 30); start = 1;
    capture(60, 0);
    vectors++; if (ne !== 2 || e_cyc[0] !== 1 || e_cyc[1] !== 9) begin miscompares++; $display("FAIL clamp_edges got n=%0d %0d,%0d want 2 1,9", ne, e_cyc[0], e_cyc[1]); end
    vectors++; if (fin !== 17) begin miscompares++; $display("FAIL clamp_finish got %0d want 17", fin); end
    vectors++; if (wbad !== 0) begin miscompares++; $display("FAIL clamp_width got %0d bad pulses want 0", wbad); end
    @(negedge clk);
  endtask
  task automatic test_abort;
    int saw_fin = 0;
    set_par(6, 2, 100, 40, 30); start = 1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start = 0;
      if (finish) saw_fin++;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vectors++; if ({step, busy, aborted} !== 3'b001) begin miscompares++; $display("FAIL abort_flags got step,busy,aborted=%b want 001", {step, busy, aborted}); end
    vectors++; if (step_count !== 32'd2) begin miscompares++; $display("FAIL abort_count got %0d want 2", step_count); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (finish || step) saw_fin++;
    end
    vectors++; if (saw_fin !== 0 || aborted !== 1'b0) begin miscompares++; $display("FAIL abort_quiet got activity=%0d aborted=%b want 0 0", saw_fin, aborted); end
    abort = 1;
    repeat (2) @(negedge clk);
    vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL abort_idle got %b want 0", aborted); end
    abort = 0;
  endtask
  task automatic test_back_to_back;
    set_par(3, 5, 100, 40, 30); start = 1;
    capture(400, 1);
    vectors++; if (ne !== 3 || e_cyc[1] !== 101 || e_cyc[2] !== 141) begin miscompares++; $display("FAIL held_start edges got n=%0d %0d,%0d want 3 101,141", ne, e_cyc[1], e_cyc[2]); end
    vectors++; if (fin !== 211) begin miscompares++; $display("FAIL held_finish got %0d want 211", fin); end
    @(negedge clk);
    vectors++; if (step !== 1'b0 || step_count !== 32'd3) begin miscompares++; $display("FAIL after_finish got step=%b count=%0d want 0 3", step, step_count); end
    capture(400, 0);
    vectors++; if (e_cyc[0] !== 1 || cnt_first !== 1) begin miscompares++; $display("FAIL b2b_first got edge=%0d count=%0d want 1 1", e_cyc[0], cnt_first); end
    vectors++; if (fin !== 211) begin miscompares++; $display("FAIL b2b_finish got %0d want 211", fin); end
    @(negedge clk);
  endtask
  task automatic test_async_reset;
    int exp[6] = '{1, 101, 171, 211, 251, 321};
    set_par(6, 2, 100, 40, 30); start = 1;
    for (int c = 1; c <= 220; c++) begin
      @(negedge clk);
      start = 0;
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    #2 rst = 1;
    #1;
    vectors++; if ({step, busy, finish, aborted} !== 4'b0 || step_count !== 32'd0) begin miscompares++; $display("FAIL async_reset got flags=%b count=%0d want 0 0", {step, busy, finish, aborted}, step_count); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL reset_no_finish got %b want 0", finish); end
    start = 1;
    capture(600, 0);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (e_cyc[i] !== exp[i]) begin miscompares++; $display("FAIL rerun_edge%0d got %0d want %0d", i, e_cyc[i], exp[i]); end
    end
    vectors++; if (fin !== 421 || step_count !== 32'd6) begin miscompares++; $display("FAIL rerun_finish got fin=%0d count=%0d want 421 6", fin, step_count); end
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_short;
    test_zero_and_clamp;
    test_abort;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
